framebuf_arbiter: RTL and testbench

FRAMEBUF_ARBITER -- requirements
Module: framebuf_arbiter

---
 rtl/framebuf_pkg.sv | 22 ++
 rtl/framebuf_arbiter_rd_lat_pipe.sv | 33 +++
 rtl/framebuf_arbiter.sv | 132 +++++++++++++
 tb/tb_framebuf_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/framebuf_pkg.sv
// rtl/framebuf_pkg.sv - shared state/grant types and default parameters for framebuf_arbiter
package framebuf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_BURST = 2'd1,
        ST_WR_BURST = 2'd2
    } state_e;

    typedef enum logic {
        GNT_RD = 1'b0,
        GNT_WR = 1'b1
    } grant_e;

    localparam int DEF_ADDR_W     = 21;
    localparam int DEF_DATA_W     = 24;
    localparam int DEF_BURST_LEN  = 16;
    localparam int DEF_FB_WORDS   = 307200;
    localparam int DEF_RD_LAT     = 2;
    localparam int DEF_STARVE_MAX = 64;

endpackage

// File: rtl/framebuf_arbiter_rd_lat_pipe.sv
// rtl/framebuf_arbiter_rd_lat_pipe.sv - read-strobe delay line that qualifies returning memory data
module rd_lat_pipe #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;

    always_comb begin
        vld_d = (vld_q << 1) | DEPTH'(in_valid);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Memory returns the word itself after the latency; only the qualifier is delayed.
    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = out_valid ? in_data : '0;

endmodule

// File: rtl/framebuf_arbiter.sv
// rtl/framebuf_arbiter.sv - burst arbiter between HDMI reader and camera writer on one frame-buffer port
module framebuf_arbiter
    import framebuf_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int FB_WORDS   = DEF_FB_WORDS,
    parameter int RD_LAT     = DEF_RD_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk_low,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_urgent,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_pop,
    output logic              wr_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int BEAT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0]   LAST_ADDR  = ADDR_W'(FB_WORDS - 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    state_e              state_q, state_d;
    grant_e              last_q, last_d, grant;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                in_rd, in_wr, last_beat;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        addr_d   = addr_q;
        beat_d   = beat_q;
        starve_d = starve_q;
        grant    = GNT_RD;

        if (wr_req && state_q != ST_WR_BURST && starve_q != STARVE_LIM) begin
            starve_d = starve_q + STARVE_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (rd_req || wr_req) begin
                    if (rd_req && wr_req) begin
                        // Starvation guard beats urgency; otherwise alternate on ties.
                        if (starve_q == STARVE_LIM)       grant = GNT_WR;
                        else if (rd_urgent)               grant = GNT_RD;
                        else grant = (last_q == GNT_RD) ? GNT_WR : GNT_RD;
                    end else begin
                        grant = wr_req ? GNT_WR : GNT_RD;
                    end
                    last_d = grant;
                    beat_d = '0;
                    if (grant == GNT_WR) begin
                        state_d  = ST_WR_BURST;
                        addr_d   = wr_addr;
                        starve_d = '0;
                    end else begin
                        state_d  = ST_RD_BURST;
                        addr_d   = rd_addr;
                    end
                end
            end
            ST_RD_BURST, ST_WR_BURST: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = ST_IDLE;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                    addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_low) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            last_q   <= GNT_RD;
            addr_q   <= '0;
            beat_q   <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            beat_q   <= beat_d;
            starve_q <= starve_d;
        end
    end

    assign in_rd     = (state_q == ST_RD_BURST);
    assign in_wr     = (state_q == ST_WR_BURST);
    assign last_beat = (beat_q == LAST_BEAT);

    assign mem_en    = in_rd | in_wr;
    assign mem_we    = in_wr;
    assign mem_addr  = mem_en ? addr_q : '0;
    assign mem_wdata = in_wr ? wr_data : '0;
    assign wr_pop    = in_wr;
    assign rd_ack    = in_rd & last_beat;
    assign wr_ack    = in_wr & last_beat;

    rd_lat_pipe #(
        .DEPTH  (RD_LAT),
        .DATA_W (DATA_W)
    ) u_rd_lat_pipe (
        .clk       (clk_low),
        .resetn    (reset),
        .in_valid  (in_rd),
        .in_data   (mem_rdata),
        .out_valid (rd_valid),
        .out_data  (rd_data)
    );

endmodule

// File: tb/tb_framebuf_arbiter.sv
// tb/tb_framebuf_arbiter.sv - randomized and directed checks of framebuf_arbiter against a burst-queue model
module tb_framebuf_arbiter;

    localparam int ADDR_W     = 21;
    localparam int DATA_W     = 24;
    localparam int BURST_LEN  = 16;
    localparam int FB_WORDS   = 307200;
    localparam int RD_LAT     = 2;
    localparam int STARVE_MAX = 64;

    logic              clk_low   = 1'b0;
    logic              reset     = 1'b0;
    logic              rd_req    = 1'b0;
    logic [ADDR_W-1:0] rd_addr   = '0;
    logic              rd_urgent = 1'b0;
    logic              wr_req    = 1'b0;
    logic [ADDR_W-1:0] wr_addr   = '0;
    logic [DATA_W-1:0] wr_data   = '0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              rd_ack, rd_valid, wr_pop, wr_ack, mem_en, mem_we;
    logic [DATA_W-1:0] rd_data, mem_wdata;
    logic [ADDR_W-1:0] mem_addr;

    int checks   = 0;
    int failures = 0;

    framebuf_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN),
        .FB_WORDS(FB_WORDS), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk_low(clk_low), .reset(reset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_urgent(rd_urgent),
        .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_pop(wr_pop), .wr_ack(wr_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk_low = ~clk_low;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a granted burst becomes a queue of pending beats; an empty queue is an idle cycle.
    typedef struct {
        bit we;
        int addr;
    } beat_t;

    beat_t beats[$];
    bit    strobes[$];
    int    starve      = 0;
    bit    last_wr     = 1'b0;
    bit    model_live  = 1'b0;
    bit    after_reset = 1'b0;

    always @(posedge clk_low) begin : model
        bit busy;
        bit cur_wr;
        bit gw;
        int old_starve;
        int base;
        if (!reset) begin
            beats.delete();
            strobes.delete();
            for (int i = 0; i < RD_LAT; i++) strobes.push_back(1'b0);
            starve      = 0;
            last_wr     = 1'b0;
            model_live  = 1'b1;
            after_reset = 1'b1;
        end else if (model_live) begin
            after_reset = 1'b0;
            busy   = beats.size() > 0;
            cur_wr = busy && beats[0].we;
            strobes.push_front(busy && !cur_wr);
            void'(strobes.pop_back());
            old_starve = starve;
            if (wr_req && !cur_wr) starve = (old_starve < STARVE_MAX) ? old_starve + 1 : STARVE_MAX;
            if (busy) begin
                void'(beats.pop_front());
            end else if (rd_req || wr_req) begin
                if (rd_req && wr_req) begin
                    if (old_starve >= STARVE_MAX) gw = 1'b1;
                    else if (rd_urgent)           gw = 1'b0;
                    else                          gw = !last_wr;
                end else begin
                    gw = wr_req;
                end
                last_wr = gw;
                if (gw) starve = 0;
                base = gw ? int'(wr_addr) : int'(rd_addr);
                for (int i = 0; i < BURST_LEN; i++) beats.push_back('{we: gw, addr: (base + i) % FB_WORDS});
            end
        end
    end

    always @(negedge clk_low) begin : compare
        bit busy;
        bit ewr;
        bit evld;
        if (model_live) begin
            busy = beats.size() > 0;
            ewr  = busy && beats[0].we;
            evld = strobes[RD_LAT-1];
            check("cmp mem_en",   64'(mem_en),   64'(busy));
            check("cmp mem_we",   64'(mem_we),   64'(ewr));
            check("cmp wr_pop",   64'(wr_pop),   64'(ewr));
            check("cmp rd_ack",   64'(rd_ack),   64'(busy && !ewr && beats.size() == 1));
            check("cmp wr_ack",   64'(wr_ack),   64'(ewr && beats.size() == 1));
            check("cmp rd_valid", 64'(rd_valid), 64'(evld));
            if (busy) check("cmp mem_addr",  64'(mem_addr),  64'(beats[0].addr));
            if (ewr)  check("cmp mem_wdata", 64'(mem_wdata), 64'(wr_data));
            if (evld) check("cmp rd_data",   64'(rd_data),   64'(mem_rdata));
            if (after_reset) begin
                check("reset mem_addr",  64'(mem_addr),  64'(0));
                check("reset mem_wdata", 64'(mem_wdata), 64'(0));
                check("reset rd_data",   64'(rd_data),   64'(0));
            end
        end
    end

    bit burst_log[$];
    bit prev_en = 1'b0;

    always @(negedge clk_low) begin
        if (mem_en && !prev_en) burst_log.push_back(mem_we);
        prev_en = mem_en;
    end

    initial begin
        forever begin
            @(posedge clk_low);
            #1;
            mem_rdata = DATA_W'($urandom);
            wr_data   = DATA_W'($urandom);
        end
    end

    task automatic tick();
        @(posedge clk_low);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; rd_req = 1'b0; wr_req = 1'b0; rd_urgent = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin : stimulus
        int vcnt;
        int pops;
        int ens;
        int acks;

        do_reset();
        check("lit reset mem_en", 64'(mem_en), 64'(0));
        check("lit reset rd_valid", 64'(rd_valid), 64'(0));

        // single read burst at address 100
        rd_addr = ADDR_W'(100); rd_req = 1'b1; vcnt = 0;
        for (int i = 0; i < BURST_LEN; i++) begin
            tick();
            check("lit rd addr", 64'(mem_addr), 64'(100 + i));
            check("lit rd ack", 64'(rd_ack), 64'(i == 15));
            check("lit rd valid latency", 64'(rd_valid), 64'(i >= 2));
            vcnt += int'(rd_valid);
            if (i == 15) rd_req = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            vcnt += int'(rd_valid);
        end
        check("lit rd valid count", 64'(vcnt), 64'(16));

        // tie without urgency alternates, writer first
        do_reset();
        burst_log.delete();
        rd_addr = ADDR_W'(300); wr_addr = ADDR_W'(200); rd_req = 1'b1; wr_req = 1'b1;
        repeat (3 * 17 + 2) tick();
        check("lit tie bursts", 64'(burst_log.size() >= 3), 64'(1));
        if (burst_log.size() >= 3) begin
            check("lit tie first", 64'(burst_log[0]), 64'(1));
            check("lit tie second", 64'(burst_log[1]), 64'(0));
            check("lit tie third", 64'(burst_log[2]), 64'(1));
        end

        // urgent reads win four bursts, then starvation forces one write
        do_reset();
        burst_log.delete();
        rd_urgent = 1'b1; rd_req = 1'b1; wr_req = 1'b1;
        repeat (5 * 17 + 2) tick();
        check("lit urgent bursts", 64'(burst_log.size() >= 5), 64'(1));
        if (burst_log.size() >= 5) begin
            for (int k = 0; k < 4; k++) check("lit urgent read", 64'(burst_log[k]), 64'(0));
            check("lit starve write", 64'(burst_log[4]), 64'(1));
        end

        // write burst wrapping the end of the frame buffer
        do_reset();
        wr_addr = ADDR_W'(FB_WORDS - 4); wr_req = 1'b1; pops = 0;
        for (int i = 0; i < BURST_LEN; i++) begin
            tick();
            check("lit wrap addr", 64'(mem_addr), 64'((i < 4) ? (307196 + i) : (i - 4)));
            check("lit wrap we", 64'(mem_we), 64'(1));
            pops += int'(wr_pop);
            if (i == 15) wr_req = 1'b0;
        end
        tick();
        check("lit wrap pops", 64'(pops), 64'(16));
        check("lit wrap idle pop", 64'(wr_pop), 64'(0));

        // reset during beat 5 of a read burst
        do_reset();
        rd_addr = ADDR_W'(500); rd_req = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("lit beat5 addr", 64'(mem_addr), 64'(504));
        reset = 1'b0; rd_req = 1'b0;
        tick();
        check("lit midreset mem_en", 64'(mem_en), 64'(0));
        check("lit midreset rd_valid", 64'(rd_valid), 64'(0));
        check("lit midreset rd_ack", 64'(rd_ack), 64'(0));
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lit postreset quiet", 64'({mem_en, rd_valid, rd_ack}), 64'(0));
        end

        // requester drops after beat 3, burst still completes
        do_reset();
        rd_addr = ADDR_W'(FB_WORDS - 2); rd_req = 1'b1; ens = 0; acks = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            ens  += int'(mem_en);
            acks += int'(rd_ack);
            if (i == 2) rd_req = 1'b0;
        end
        check("lit drop beats", 64'(ens), 64'(16));
        check("lit drop acks", 64'(acks), 64'(1));

        // randomized traffic, low then high urgency
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            reset     = ($urandom_range(149) != 0);
            rd_req    = ($urandom_range(3) != 0);
            wr_req    = ($urandom_range(3) != 0);
            rd_urgent = (n < 2000) ? ($urandom_range(3) == 0) : ($urandom_range(9) != 0);
            rd_addr   = ($urandom_range(7) == 0) ? ADDR_W'(FB_WORDS - $urandom_range(16, 1))
                                                 : ADDR_W'($urandom_range(FB_WORDS - 1));
            wr_addr   = ($urandom_range(7) == 0) ? ADDR_W'(FB_WORDS - $urandom_range(16, 1))
                                                 : ADDR_W'($urandom_range(FB_WORDS - 1));
            tick();
        end
        reset = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
